// File: rtl/serial_mac.sv
// Serial multiply-accumulate neuron lane: SIZE signed products plus bias, scaled and saturated.
// Optional build macro SERIAL_MAC_RELU_EN clamps negative results to zero after saturation.
module serial_mac #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] serial_in,
    input  logic [WIDTH-1:0] weight_in,
    input  logic [WIDTH-1:0] bias,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             sat
);

    localparam int ACC_WIDTH = 2*WIDTH + $clog2(SIZE+1) + 1;
    localparam int CNT_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SIZE-1);

    localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                       state, state_next;
    logic signed [ACC_WIDTH-1:0]  acc, acc_next;
    logic [CNT_WIDTH-1:0]         cnt, cnt_next;
    logic [WIDTH-1:0]             result_next;
    logic                         valid_next, sat_next;

    logic signed [2*WIDTH-1:0]    act_ext, wgt_ext, product;
    logic signed [ACC_WIDTH-1:0]  product_ext, bias_term, acc_base, full, shifted;
    logic [WIDTH-1:0]             clipped;
    logic                         clip_flag;
    logic                         complete;

    // Sign-extend before multiplying so the low 2*WIDTH bits hold the exact signed product.
    assign act_ext     = {{WIDTH{serial_in[WIDTH-1]}}, serial_in};
    assign wgt_ext     = {{WIDTH{weight_in[WIDTH-1]}}, weight_in};
    assign product     = act_ext * wgt_ext;
    assign product_ext = {{(ACC_WIDTH-2*WIDTH){product[2*WIDTH-1]}}, product};
    assign bias_term   = {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias} << FRAC;

    // Word 0 seeds from the bias; later words extend the running sum.
    assign acc_base = (state == IDLE) ? bias_term : acc;
    assign full     = acc_base + product_ext;
    assign shifted  = full >>> FRAC;

    always_comb begin
        clipped   = shifted[WIDTH-1:0];
        clip_flag = 1'b0;
        if (shifted > RES_MAX) begin
            clipped   = RES_MAX[WIDTH-1:0];
            clip_flag = 1'b1;
        end else if (shifted < RES_MIN) begin
            clipped   = RES_MIN[WIDTH-1:0];
            clip_flag = 1'b1;
        end
`ifdef SERIAL_MAC_RELU_EN
        if (clipped[WIDTH-1]) begin
            clipped = '0;
        end
`endif
    end

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        cnt_next    = cnt;
        result_next = result;
        sat_next    = sat;
        valid_next  = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (SIZE == 1) begin
                        complete = 1'b1;
                    end else begin
                        acc_next   = full;
                        cnt_next   = CNT_WIDTH'(1);
                        state_next = ACCUM;
                    end
                end
            end
            ACCUM: begin
                acc_next = full;
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_CNT) begin
                    complete   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (complete) begin
            result_next = clipped;
            sat_next    = clip_flag;
            valid_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            sat          <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            cnt          <= cnt_next;
            result       <= result_next;
            result_valid <= valid_next;
            sat          <= sat_next;
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_serial_mac.sv
// Scoreboard bench for serial_mac: SIZE=4 lane plus a SIZE=1 lane.
module tb_serial_mac;

    localparam int SIZE  = 4;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start, busy, result_valid, sat;
    logic [WIDTH-1:0] serial_in, weight_in, bias, result;
    logic             start1, busy1, result_valid1, sat1;
    logic [WIDTH-1:0] serial1, weight1, bias1, result1;

    serial_mac #(.SIZE(SIZE), .WIDTH(WIDTH), .FRAC(FRAC)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .serial_in(serial_in),
        .weight_in(weight_in), .bias(bias), .busy(busy), .result(result),
        .result_valid(result_valid), .sat(sat)
    );

    serial_mac #(.SIZE(1), .WIDTH(WIDTH), .FRAC(FRAC)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .serial_in(serial1),
        .weight_in(weight1), .bias(bias1), .busy(busy1), .result(result1),
        .result_valid(result_valid1), .sat(sat1)
    );

    typedef struct {
        longint res;
        longint sat;
        int     cycle;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    int     busy1_hits = 0;
    longint vec_a[SIZE];
    longint vec_w[SIZE];

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    endtask

    // Reference model: exact integer sum, floor shift, clip, optional clamp.
    task automatic modelVector(input longint b, output longint res, output longint s);
        longint sum;
        sum = b * (longint'(1) << FRAC);
        for (int i = 0; i < SIZE; i++) sum += vec_a[i] * vec_w[i];
        sum = sum >>> FRAC;
        s = 0;
        if (sum > 32767) begin sum = 32767; s = 1; end
        else if (sum < -32768) begin sum = -32768; s = 1; end
`ifdef SERIAL_MAC_RELU_EN
        if (sum < 0) sum = 0;
`endif
        res = sum;
    endtask

    task automatic applyStimulus(input longint b, input int spurious_at);
        exp_t e;
        modelVector(b, e.res, e.sat);
        e.cycle = cyc + SIZE;
        sb_q.push_back(e);
        for (int i = 0; i < SIZE; i++) begin
            start     = (i == 0) || (i == spurious_at);
            serial_in = WIDTH'(vec_a[i]);
            weight_in = WIDTH'(vec_w[i]);
            bias      = (i == 0) ? WIDTH'(b) : WIDTH'($urandom);
            @(posedge clk); #1;
            checkOutput("busy", longint'(busy), longint'(i + 1 < SIZE));
        end
        start     = 1'b0;
        serial_in = 'x;
        weight_in = 'x;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic setUniform(input longint a, input longint w);
        for (int i = 0; i < SIZE; i++) begin vec_a[i] = a; vec_w[i] = w; end
    endtask

    task automatic setBasic();
        vec_a[0] = 256; vec_a[1] = 512; vec_a[2] = -256; vec_a[3] = 768;
        for (int i = 0; i < SIZE; i++) vec_w[i] = 256;
    endtask

    // Pops the scoreboard whenever the lane reports a completed vector.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", longint'(cyc), -1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("valid_cycle", longint'(cyc), longint'(e.cycle));
                checkOutput("result", longint'($signed(result)), e.res);
                checkOutput("sat", longint'(sat), e.sat);
            end
        end
        if (busy1) busy1_hits++;
    end

    initial begin
        logic signed [WIDTH-1:0] tmp;
        rst_n = 1'b0; start = 1'b0; serial_in = '0; weight_in = '0; bias = '0;
        start1 = 1'b0; serial1 = '0; weight1 = '0; bias1 = '0;
        #12;
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_result", longint'(result), 0);
        checkOutput("reset_valid", longint'(result_valid), 0);
        checkOutput("reset_sat", longint'(sat), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        serial_in = 'x; weight_in = 'x;
        idleCycles(2);

        setBasic();
        applyStimulus(0, -1);
        idleCycles(2);
        applyStimulus(-1536, -1);
        idleCycles(2);

        setUniform(32767, 32767);
        applyStimulus(32767, -1);
        idleCycles(1);
        setUniform(-32768, 32767);
        applyStimulus(0, -1);
        idleCycles(2);

        // Back-to-back vectors, with a stray start in the middle of the first.
        setBasic();
        applyStimulus(0, 2);
        setUniform(-300, 700);
        applyStimulus(100, -1);
        idleCycles(2);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < SIZE; i++) begin
                tmp = WIDTH'($urandom); vec_a[i] = tmp;
                tmp = WIDTH'($urandom); vec_w[i] = tmp;
            end
            tmp = WIDTH'($urandom);
            applyStimulus(tmp, -1);
        end
        idleCycles(2);

        // Reset two words into a vector; result is non-zero from earlier traffic.
        setBasic();
        for (int i = 0; i < 2; i++) begin
            start = (i == 0); serial_in = WIDTH'(vec_a[i]); weight_in = WIDTH'(vec_w[i]); bias = '0;
            @(posedge clk); #1;
        end
        serial_in = WIDTH'(vec_a[2]);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", longint'(busy), 0);
        checkOutput("midreset_result", longint'(result), 0);
        checkOutput("midreset_valid", longint'(result_valid), 0);
        checkOutput("midreset_sat", longint'(sat), 0);
        sb_q.delete();
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("no_valid_after_reset", longint'(result_valid), 0);
        checkOutput("idle_after_reset", longint'(busy), 0);
        applyStimulus(0, -1);
        idleCycles(2);

        start1 = 1'b1; serial1 = 16'd512; weight1 = 16'd512; bias1 = '0;
        @(posedge clk); #1;
        start1 = 1'b0; serial1 = 'x; weight1 = 'x;
        checkOutput("size1_valid", longint'(result_valid1), 1);
        checkOutput("size1_result", longint'($signed(result1)), 1024);
        checkOutput("size1_sat", longint'(sat1), 0);
        @(posedge clk); #1;
        checkOutput("size1_valid_pulse", longint'(result_valid1), 0);
        checkOutput("size1_result_hold", longint'($signed(result1)), 1024);

        for (int t = 0; t < 20 && sb_q.size() != 0; t++) idleCycles(1);
        checkOutput("scoreboard_drain", longint'(sb_q.size()), 0);
        checkOutput("size1_busy_never", longint'(busy1_hits), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
